// File: rtl/led_fade_if.sv
// Pattern/drive bundle between the GPIO output register and the LED fader.
//   led_i  : target pattern, bit i = 1 fades channel i to full-on
//   led_o  : PWM-modulated LED drive
//   busy_o : high while any channel is still ramping
interface led_fade_if;
  logic [7:0] led_i;
  logic [7:0] led_o;
  logic       busy_o;

  modport master (output led_i, input led_o, input busy_o);
  modport slave  (input led_i, output led_o, output busy_o);
endinterface

// File: rtl/led_fade.sv
// Eight-channel LED fader: each target bit ramps an 8-bit brightness level
// one step per prescaler tick, and each level drives a PWM comparator.
// Ports:
//   wb_clk      : system clock, rising edge
//   wb_rst      : synchronous active-high reset
//   led_bus_io  : slave side of led_fade_if (led_i in, led_o/busy_o out)
module led_fade #(
  parameter int unsigned PRESCALE = 1024
) (
  input  logic           wb_clk,
  input  logic           wb_rst,
  led_fade_if.slave      led_bus_io
);

  localparam int unsigned NCH = 8;
  localparam int unsigned LW  = 8;
  localparam int unsigned PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [LW-1:0] LVL_MAX    = '1;

  typedef enum logic [1:0] {
    CH_SETTLED = 2'd0,
    CH_RISING  = 2'd1,
    CH_FALLING = 2'd2
  } ch_state_e;

  logic [NCH-1:0]         led_q,   led_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [LW-1:0]          pwm_q,   pwm_d;
  logic [NCH-1:0][LW-1:0] level_q, level_d;
  logic [NCH-1:0]         out_q,   out_d;
  logic                   busy_q,  busy_d;
  logic                   tick_c;
  ch_state_e [NCH-1:0]    ch_state_c;

  // State registers
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      led_q   <= '0;
      presc_q <= '0;
      pwm_q   <= '0;
      level_q <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      led_q   <= led_d;
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      level_q <= level_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: prescaler, PWM counter, per-channel ramp and outputs
  always_comb begin
    led_d      = led_bus_io.led_i;
    presc_d    = presc_q;
    pwm_d      = pwm_q + LW'(1);
    level_d    = level_q;
    out_d      = '0;
    busy_d     = 1'b0;
    ch_state_c = '{default: CH_SETTLED};

    tick_c  = (presc_q == PRESC_LAST);
    presc_d = tick_c ? '0 : presc_q + PW'(1);

    for (int i = 0; i < NCH; i++) begin
      // Direction comes from the registered target, so a mid-ramp
      // reversal simply continues from the current level.
      if (led_q[i] && (level_q[i] != LVL_MAX)) begin
        ch_state_c[i] = CH_RISING;
      end else if (!led_q[i] && (level_q[i] != '0)) begin
        ch_state_c[i] = CH_FALLING;
      end

      if (tick_c) begin
        unique case (ch_state_c[i])
          CH_RISING:  level_d[i] = level_q[i] + LW'(1);
          CH_FALLING: level_d[i] = level_q[i] - LW'(1);
          default:    level_d[i] = level_q[i];
        endcase
      end

      // Full level forced on so 255 is steady rather than 255/256 duty.
      out_d[i] = (level_q[i] == LVL_MAX) || (level_q[i] > pwm_q);
      busy_d   = busy_d || (ch_state_c[i] != CH_SETTLED);
    end
  end

  assign led_bus_io.led_o  = out_q;
  assign led_bus_io.busy_o = busy_q;

endmodule

// File: doc/led_fade.md
# led_fade

Output stage between the GPIO block's 8-bit output register and the board LEDs. Each output bit becomes an 8-bit brightness level that ramps linearly toward full-on or full-off at a programmable rate. Each level drives an 8-bit PWM comparator, so pattern changes written by the mapper appear as smooth fades instead of hard steps.

## Interface
- PRESCALE, 1024: clock cycles per brightness step (tick period); legal range ≥ 1.
- wb_clk  in  1  system clock; all logic on rising edge.
- wb_rst  in  1  synchronous, active-high reset.
- led_i  in  8  target pattern from the GPIO output; bit i = 1 means channel i fades to full-on.
- led_o  out  8  PWM-modulated LED drive.
- busy_o  out  1  high while any channel level differs from its target.

## Operation
- Input register: led_q <= led_i every cycle. All decisions use led_q, never led_i directly.
- Prescaler:
  - presc counts 0..PRESCALE-1 and wraps to 0.
  - tick = (presc == PRESCALE-1).
  - With PRESCALE = 1, tick is high every cycle.
  - Counter width is $clog2(PRESCALE), minimum 1 bit.
- PWM counter: pwm_cnt is 8 bits, increments every cycle, wraps 255 -> 0. It is free-running and independent of tick.
- Per-channel level[i], 8 bits, unsigned; updated only on tick:
  - led_q[i] = 1 and level[i] < 255: level[i] + 1.
  - led_q[i] = 0 and level[i] > 0: level[i] - 1.
  - Otherwise hold. Saturate at 0 and 255; never wrap.
- Each channel has an implicit 3-state behaviour: RISING, FALLING, SETTLED (level at target).
  - A target change mid-ramp reverses direction from the current level. No jump, no restart.
- Output: led_o[i] <= (level[i] == 255) ? 1 : (level[i] > pwm_cnt).
  - Level 0 is never on.
  - Level L in 1..254 is on exactly L cycles of every 256-cycle PWM period.
  - Level 255 is constantly on.
- busy_o <= OR over i of (level[i] != (led_q[i] ? 255 : 0)).
- Channels are fully independent; one shared prescaler and one shared pwm_cnt.

## Timing
- Reset values (wb_rst high at an edge; effective that edge): led_q = 0, presc = 0, pwm_cnt = 0, level[*] = 0, led_o = 0, busy_o = 0.
- Reset mid-ramp:
  - All levels drop to 0 at the reset edge; no fade-out.
  - led_o is 0 from the first edge after reset assertion onward.
  - busy_o is 0 one cycle after that.
- First tick after reset release occurs PRESCALE cycles after the release edge.
- Target latency:
  - led_i change at edge N is visible in led_q at N+1.
  - The first level step occurs on the first tick at or after N+1.
  - busy_o rises at the edge after led_q differs from the level target, so at most 2 cycles after the led_i change.
- Full ramp 0 -> 255 (or 255 -> 0) takes 255 ticks = 255·PRESCALE cycles, ±1 tick of alignment.
- led_o latency: one cycle from level/pwm_cnt to the registered output.
- A level change takes effect on led_o within the same PWM period. No period alignment is required.
- Simultaneous tick and target reversal:
  - The step uses the new led_q value if led_q has already updated.
  - Otherwise it uses the old value; the reversal applies from the next tick.
- led_i toggling faster than one tick: only led_q sampled at tick edges matters. Level moves at most ±1 per tick.

## Test plan
- Reset/idle: PRESCALE = 4, wb_rst for 3 cycles, led_i = 8'h00 for 2000 cycles -> led_o == 0 and busy_o == 0 throughout.
- Single fade-in: PRESCALE = 4, led_i = 8'h01 -> busy_o = 1 within 2 cycles.
  - level[0] reaches 255 after 1020 ±4 cycles; busy_o drops the next cycle.
  - led_o[0] is constant 1 afterwards; led_o[7:1] stays 0.
- Duty check: PRESCALE = 4096, led_i = 8'hFF. In every aligned 256-cycle window, the count of led_o[i] highs equals the model level. Verify at levels 1, 64, 128, 254.
- Reversal: PRESCALE = 4, led_i = 8'h01 for 100 ticks, then 8'h00.
  - level[0] peaks at 100 ±1, then decreases monotonically with no jump.
  - Reaches 0 about 100 ticks later; led_o[0] stays 0 after that.
- Independent channels: PRESCALE = 2, led_i = 8'hA5 from reset.
  - After 520 cycles: levels 255 on bits 0, 2, 5, 7 and 0 on the others.
  - Then led_i = 8'h5A: fades cross, and busy_o stays 1 for about 510 cycles.
- Reset mid-operation: PRESCALE = 4, fade 8'hFF to level ~128, assert wb_rst for 1 cycle.
  - Next cycle: led_o == 0, all levels 0.
  - After release with led_i still 8'hFF, the fade restarts from 0.
